mm_tile_scheduler: RTL and testbench

Sequences multi-pass matrix multiplies through the parallel BRAM matrix-multiply engine. Each pass uses one weight tile. For every tile, the scheduler:
- requests a weight load for that tile,
- issues one val/rdy start to the engine,
- counts result-row writes until the pass is complete.
It then advances to the next tile and pulses done after the last one. It sits between the host/command logic and the engine plus its weight-tile store.

---
 rtl/mm_tile_scheduler_if.sv | 35 +++
 rtl/mm_tile_scheduler.sv | 90 +++++++++
 tb/tb_mm_tile_scheduler.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mm_tile_scheduler_if.sv
// mm_tile_scheduler_if: command, weight-load and engine handshake bundle for
// mm_tile_scheduler.
//   master : host/engine side (drives start, num_tiles, abort, wt_load_ack,
//            mm_rdy_in, mm_row_wr_en)
//   slave  : scheduler side (drives busy, done, err, wt_load_req,
//            wt_tile_sel, mm_val_in)
interface mm_tile_scheduler_if #(
   parameter int COL_NUM  = 32,
   parameter int TILE_NUM = 4
);
   localparam int TILE_ADDR_WIDTH = (TILE_NUM > 1) ? $clog2(TILE_NUM) : 1;

   logic                       start;
   logic [TILE_ADDR_WIDTH:0]   num_tiles;
   logic                       abort;
   logic                       busy;
   logic                       done;
   logic                       err;
   logic                       wt_load_req;
   logic                       wt_load_ack;
   logic [TILE_ADDR_WIDTH-1:0] wt_tile_sel;
   logic                       mm_val_in;
   logic                       mm_rdy_in;
   logic [COL_NUM-1:0]         mm_row_wr_en;

   modport master (
      output start, num_tiles, abort, wt_load_ack, mm_rdy_in, mm_row_wr_en,
      input  busy, done, err, wt_load_req, wt_tile_sel, mm_val_in
   );

   modport slave (
      input  start, num_tiles, abort, wt_load_ack, mm_rdy_in, mm_row_wr_en,
      output busy, done, err, wt_load_req, wt_tile_sel, mm_val_in
   );
endinterface

// File: rtl/mm_tile_scheduler.sv
// mm_tile_scheduler: runs a multi-pass matrix multiply, one weight tile per
// pass. Per tile: request weight load, issue one val/rdy start to the engine,
// count ROW_NUM result-row writes, then move to the next tile. done pulses
// once after the last tile.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : mm_tile_scheduler_if.slave (command, weight load, engine ports)
module mm_tile_scheduler #(
   parameter int ROW_NUM  = 32,
   parameter int COL_NUM  = 32,
   parameter int TILE_NUM = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mm_tile_scheduler_if.slave   bus
);
   localparam int ROW_ADDR_WIDTH  = $clog2(ROW_NUM);
   localparam int TILE_ADDR_WIDTH = (TILE_NUM > 1) ? $clog2(TILE_NUM) : 1;

   localparam logic [TILE_ADDR_WIDTH:0] TILE_MAX = (TILE_ADDR_WIDTH + 1)'(TILE_NUM);
   localparam logic [ROW_ADDR_WIDTH:0]  ROW_LAST = (ROW_ADDR_WIDTH + 1)'(ROW_NUM - 1);

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, RUN, NEXT, DONE} state_t;

   state_t                     state_q, state_d;
   logic [TILE_ADDR_WIDTH-1:0] tile_q;
   logic [TILE_ADDR_WIDTH:0]   num_q;
   logic [ROW_ADDR_WIDTH:0]    row_q;
   logic                       err_q;

   logic num_legal;
   logic last_tile;
   logic wr0;

   assign num_legal = (bus.num_tiles != '0) && (bus.num_tiles <= TILE_MAX);
   assign last_tile = ({1'b0, tile_q} == (num_q - 1'b1));
   // All lanes write together, so lane 0 stands for the whole row.
   assign wr0       = bus.mm_row_wr_en[0];

   always_comb begin
      state_d = state_q;
      if (bus.abort && state_q != IDLE) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bus.start && num_legal) state_d = LOAD;
            LOAD:    if (bus.wt_load_ack) state_d = ISSUE;
            ISSUE:   if (bus.mm_rdy_in) state_d = RUN;
            RUN:     if (wr0 && row_q == ROW_LAST) state_d = NEXT;
            NEXT:    state_d = last_tile ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tile_q  <= '0;
         num_q   <= '0;
         row_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.start) begin
            if (num_legal) begin
               num_q  <= bus.num_tiles;
               tile_q <= '0;
               err_q  <= 1'b0;
            end else begin
               err_q  <= 1'b1;
            end
         end
         if (state_q == ISSUE && bus.mm_rdy_in) row_q <= '0;
         if (state_q == RUN && wr0) row_q <= row_q + 1'b1;
         // Keyed on state_d so an abort in NEXT leaves the tile index alone.
         if (state_q == NEXT && state_d == LOAD) tile_q <= tile_q + 1'b1;
         // A write outside RUN is flagged but does not disturb the sequence.
         if (wr0 && state_q != RUN) err_q <= 1'b1;
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = (state_q == DONE);
   assign bus.err         = err_q;
   assign bus.wt_load_req = (state_q == LOAD);
   assign bus.mm_val_in   = (state_q == ISSUE);
   assign bus.wt_tile_sel = (state_q == IDLE) ? '0 : tile_q;
endmodule

// File: tb/tb_mm_tile_scheduler.sv
// tb_mm_tile_scheduler: randomized job bench for mm_tile_scheduler. Each job's
// ack/rdy stalls and write gaps are drawn up front; the expected done cycle,
// handshake count and load order follow from that per-tile cycle budget.
module tb_mm_tile_scheduler;
   localparam int ROW_NUM  = 32;
   localparam int COL_NUM  = 32;
   localparam int TILE_NUM = 4;
   localparam int NT_W     = $clog2(TILE_NUM) + 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   mm_tile_scheduler_if #(.COL_NUM(COL_NUM), .TILE_NUM(TILE_NUM)) bus();

   mm_tile_scheduler #(.ROW_NUM(ROW_NUM), .COL_NUM(COL_NUM), .TILE_NUM(TILE_NUM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drive_idle();
      bus.start        = 1'b0;
      bus.num_tiles    = '0;
      bus.abort        = 1'b0;
      bus.wt_load_ack  = 1'b0;
      bus.mm_rdy_in    = 1'b0;
      bus.mm_row_wr_en = '0;
   endtask

   // One job of n tiles. Stalls fixed per tile in [lo,hi]; gap_max idle
   // cycles may precede each row write. abort_tile<0 means no abort.
   task automatic run_job(input int n, input int aw_lo, input int aw_hi,
                          input int rw_lo, input int rw_hi, input int gap_max,
                          input bit spur, input bit start_in_run,
                          input int abort_tile, input int abort_after);
      int aw[TILE_NUM];
      int rw[TILE_NUM];
      int gp[TILE_NUM][ROW_NUM];
      int exp_done, tile, cnt, wi, gleft, hs, loads, nd;
      bit writing, exp_err, fin, aborted, post;
      exp_done = 0;
      for (int t = 0; t < n; t++) begin
         aw[t] = $urandom_range(aw_hi, aw_lo);
         rw[t] = $urandom_range(rw_hi, rw_lo);
         // LOAD aw+1, ISSUE rw+1, RUN rows+gaps, NEXT 1
         exp_done += aw[t] + rw[t] + ROW_NUM + 3;
         for (int w = 0; w < ROW_NUM; w++) begin
            gp[t][w] = $urandom_range(gap_max, 0);
            exp_done += gp[t][w];
         end
      end
      @(negedge clk);
      exp_done += cyc + 1;
      drive_idle();
      bus.start     = 1'b1;
      bus.num_tiles = NT_W'(n);
      tile = 0; cnt = 0; wi = 0; gleft = 0; hs = 0; loads = 0;
      writing = 0; exp_err = 0; fin = 0; aborted = 0; post = 0;
      for (int b = 0; b < 4000 && !fin; b++) begin
         @(negedge clk);
         bus.start        = 1'b0;
         bus.abort        = 1'b0;
         bus.wt_load_ack  = 1'($urandom);
         bus.mm_rdy_in    = 1'($urandom);
         bus.mm_row_wr_en = $urandom;
         bus.mm_row_wr_en[0] = 1'b0;
         if (aborted) begin
            check("abort_busy", 32'(bus.busy), 0);
            check("abort_outs", {bus.done, bus.wt_load_req, bus.mm_val_in, bus.wt_tile_sel}, 0);
            fin = 1;
         end else if (post) begin
            check("post_done_idle", {bus.busy, bus.done}, 0);
            fin = 1;
         end else if (bus.done) begin
            check("done_cycle", cyc, exp_done);
            check("handshakes", hs, n);
            check("loads", loads, n);
            check("err_at_done", 32'(bus.err), 32'(exp_err));
            post = 1;
         end else if (bus.wt_load_req) begin
            if (cnt == 0) begin
               check("load_tile", 32'(bus.wt_tile_sel), tile);
               loads++;
               if (spur && tile == 0) begin
                  bus.mm_row_wr_en[0] = 1'b1;
                  exp_err = 1;
               end
            end
            if (cnt == aw[tile]) begin
               bus.wt_load_ack = 1'b1;
               cnt = 0;
            end else begin
               bus.wt_load_ack = 1'b0;
               cnt++;
            end
         end else if (bus.mm_val_in) begin
            if (cnt == rw[tile]) begin
               bus.mm_rdy_in = 1'b1;
               hs++;
               cnt = 0;
               writing = 1;
               wi = 0;
               gleft = gp[tile][0];
            end else begin
               bus.mm_rdy_in = 1'b0;
               cnt++;
            end
         end else if (writing) begin
            if (abort_tile == tile && wi == abort_after) begin
               bus.abort = 1'b1;
               aborted = 1;
            end else if (gleft > 0) begin
               gleft--;
            end else begin
               bus.mm_row_wr_en[0] = 1'b1;
               wi++;
               if (start_in_run && wi == 5) begin
                  bus.start     = 1'b1;
                  bus.num_tiles = NT_W'($urandom_range(TILE_NUM, 1));
               end
               if (wi == ROW_NUM) begin
                  writing = 0;
                  tile++;
               end else begin
                  gleft = gp[tile][wi];
               end
            end
         end
      end
      if (!fin) check("job_timeout", 0, 1);
      if (aborted) begin
         nd = 0;
         repeat (4) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
         end
         check("no_done_after_abort", nd, 0);
      end
      drive_idle();
   endtask

   initial begin
      int bad[3];
      bit seen;
      int nd;
      drive_idle();
      #1 reset = 1'b0;
      #2;
      check("reset_outs", {bus.busy, bus.done, bus.err, bus.wt_load_req, bus.mm_val_in, bus.wt_tile_sel}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {bus.busy, bus.done, bus.err}, 0);

      // single tile, zero-wait, back-to-back writes: done at T+36
      run_job(1, 0, 0, 0, 0, 0, 0, 0, -1, 0);
      // three tiles: ack after 3, rdy low 5
      run_job(3, 3, 3, 5, 5, 0, 0, 0, -1, 0);

      // illegal tile counts leave the FSM idle and set err
      bad[0] = 0; bad[1] = 5; bad[2] = 7;
      foreach (bad[i]) begin
         @(negedge clk);
         bus.start     = 1'b1;
         bus.num_tiles = NT_W'(bad[i]);
         @(negedge clk);
         bus.start = 1'b0;
         check("illegal_busy", 32'(bus.busy), 0);
         check("illegal_err", 32'(bus.err), 1);
      end
      // legal job clears err (checked at done)
      run_job(2, 0, 1, 0, 1, 1, 0, 0, -1, 0);

      // abort after 10 writes on tile 1 of 2, then restart from tile 0
      run_job(2, 0, 2, 0, 2, 1, 0, 0, 1, 10);
      run_job(2, 0, 2, 0, 2, 1, 0, 0, -1, 0);

      // spurious write in LOAD and start pulsed during RUN
      run_job(2, 1, 2, 0, 2, 1, 1, 1, -1, 0);

      for (int j = 0; j < 6; j++)
         run_job($urandom_range(TILE_NUM, 1), 0, 3, 0, 3, 2,
                 1'($urandom), 1'($urandom), -1, 0);

      // async reset while in ISSUE
      @(negedge clk);
      bus.start     = 1'b1;
      bus.num_tiles = NT_W'(1);
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         bus.start       = 1'b0;
         bus.wt_load_ack = 1'b1;
         bus.mm_rdy_in   = 1'b0;
         if (bus.mm_val_in) seen = 1;
      end
      check("reach_issue", 32'(seen), 1);
      #2 reset = 1'b0;
      #1;
      check("async_reset_outs", {bus.busy, bus.done, bus.err, bus.wt_load_req, bus.mm_val_in, bus.wt_tile_sel}, 0);
      @(negedge clk);
      reset = 1'b1;
      drive_idle();
      nd = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.busy || bus.done) nd++;
      end
      check("idle_after_async_reset", nd, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
